// File: rtl/sr_latch_driver.sv
// Clocked front end for a NOR SR latch: turns single-cycle set/clear requests
// into exclusive, fixed-width S/R pulses and confirms the result via a synchronised readback.
module sr_latch_driver #(
  parameter int unsigned PULSE_W     = 4,
  parameter int unsigned GAP_W       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_fb,
  output logic s_out,
  output logic r_out,
  output logic ready,
  output logic done,
  output logic err_timeout,
  output logic err_conflict,
  output logic q_sync
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  localparam int unsigned MAX_PG  = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned CNT_MAX = (MAX_PG > TIMEOUT) ? MAX_PG : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [1:0]             state_q, state_d;
  logic                   op_q, op_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   s_q, s_d;
  logic                   r_q, r_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
  logic                   tout_q, tout_d;
  logic                   conf_q, conf_d;
  logic [SYNC_STAGES-1:0] sync_q;

  // Readback synchroniser for the asynchronous latch output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], q_fb};
  end

  assign q_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 1'b0;
      cnt_q   <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      conf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
      conf_q  <= conf_d;
    end
  end

  // Next state; drives are derived from the next state so they leave the flops already aligned
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    tout_d  = 1'b0;
    conf_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (set_req ^ clr_req) begin
          op_d    = set_req;
          cnt_d   = '0;
          state_d = ST_PULSE;
        end else if (set_req && clr_req) begin
          conf_d = 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == CNT_W'(PULSE_W - 1)) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_W - 1)) begin
          cnt_d   = '0;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (q_sync == op_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tout_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    s_d     = (state_d == ST_PULSE) &&  op_d;
    r_d     = (state_d == ST_PULSE) && !op_d;
    ready_d = (state_d == ST_IDLE);
  end

  assign s_out        = s_q;
  assign r_out        = r_q;
  assign ready        = ready_q;
  assign done         = done_q;
  assign err_timeout  = tout_q;
  assign err_conflict = conf_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboarded bench for sr_latch_driver with a behavioural latch model on q_fb.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic q_fb;
  logic s_out, r_out, ready, done, err_timeout, err_conflict, q_sync;

  logic latch_q = 1'b0;
  logic stuck   = 1'b0;

  localparam logic [2:0] EV_DONE = 3'b001;
  localparam logic [2:0] EV_TOUT = 3'b010;
  localparam logic [2:0] EV_CONF = 3'b100;

  typedef struct {
    logic [2:0] kind;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails  = 0;
  int   ncyc   = 0;
  int   base;

  sr_latch_driver dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .q_fb(q_fb),
    .s_out(s_out), .r_out(r_out), .ready(ready), .done(done),
    .err_timeout(err_timeout), .err_conflict(err_conflict), .q_sync(q_sync)
  );

  always #5 clk = ~clk;

  // NOR latch: Q follows S/R one cycle later; stuck forces a dead readback
  always @(posedge clk) begin
    if (s_out)      latch_q <= 1'b1;
    else if (r_out) latch_q <= 1'b0;
  end
  assign q_fb = stuck ? 1'b0 : latch_q;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic push(input logic [2:0] kind, input int cyc);
    exp_t e;
    e.kind = kind;
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  task automatic start(input logic s, input logic c, output int b);
    @(negedge clk); #1;
    set_req = s;
    clr_req = c;
    b = ncyc;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a completion event
  always @(negedge clk) begin
    ncyc++;
    chk("s_and_r_exclusive", int'(s_out & r_out), 0);
    if (done || err_timeout || err_conflict) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_event: got kind %b expected none (cycle %0d)",
                 {err_conflict, err_timeout, done}, ncyc);
      end else begin
        mon_e = sb.pop_front();
        chk("event_kind", int'({err_conflict, err_timeout, done}), int'(mon_e.kind));
        chk("event_cycle", ncyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle_cycles(3); #1;
    chk("rst_s_out", int'(s_out), 0);
    chk("rst_r_out", int'(r_out), 0);
    chk("rst_q_sync", int'(q_sync), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_ready", int'(ready), 1);

    // Set with full timeline
    start(1'b1, 1'b0, base);
    push(EV_DONE, base + 8);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); #1;
      set_req = 1'b0;
      chk($sformatf("set_s_out_e%0d", k), int'(s_out), int'(k <= 3));
      chk($sformatf("set_r_out_e%0d", k), int'(r_out), 0);
      chk($sformatf("set_ready_e%0d", k), int'(ready), int'(k >= 7));
    end
    chk("set_q_sync", int'(q_sync), 1);

    // Clear after set
    start(1'b0, 1'b1, base);
    push(EV_DONE, base + 8);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); #1;
      clr_req = 1'b0;
      chk($sformatf("clr_r_out_e%0d", k), int'(r_out), int'(k <= 3));
      chk($sformatf("clr_s_out_e%0d", k), int'(s_out), 0);
      chk($sformatf("clr_ready_e%0d", k), int'(ready), int'(k >= 7));
    end
    chk("clr_q_sync", int'(q_sync), 0);

    // Conflicting requests
    start(1'b1, 1'b1, base);
    push(EV_CONF, base + 1);
    @(negedge clk); #1;
    set_req = 1'b0;
    clr_req = 1'b0;
    chk("conf_s_out", int'(s_out), 0);
    chk("conf_r_out", int'(r_out), 0);
    chk("conf_ready", int'(ready), 1);
    idle_cycles(2); #1;
    chk("conf_stays_idle", int'(ready), 1);

    // Reset mid-pulse aborts the operation silently
    start(1'b1, 1'b0, base);
    @(negedge clk); #1;
    set_req = 1'b0;
    @(negedge clk); #1;
    chk("abort_pre_s_out", int'(s_out), 1);
    rst = 1'b1;
    #1;
    chk("abort_s_out", int'(s_out), 0);
    chk("abort_r_out", int'(r_out), 0);
    idle_cycles(2); #1;
    rst = 1'b0;
    #1;
    chk("abort_ready", int'(ready), 1);
    chk("abort_q_sync", int'(q_sync), 0);
    idle_cycles(12);

    // Requests while busy are dropped
    start(1'b1, 1'b0, base);
    push(EV_DONE, base + 8);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      set_req = (k == 2) || (k == 6);
      if (k == 7) chk("busy_ready", int'(ready), 1);
    end
    set_req = 1'b0;
    idle_cycles(4); #1;
    chk("busy_idle", int'(ready), 1);

    // Dead readback times out
    stuck = 1'b1;
    start(1'b1, 1'b0, base);
    push(EV_TOUT, base + 23);
    for (int k = 0; k < 26; k++) begin
      @(negedge clk); #1;
      set_req = 1'b0;
      if (k == 21) chk("tout_ready_busy", int'(ready), 0);
      if (k == 22) chk("tout_ready_back", int'(ready), 1);
    end
    stuck = 1'b0;

    idle_cycles(5);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Clocked controller directly upstream of the NOR SR latch. It turns single-cycle set/clear requests into S and R pulses that are clean, mutually exclusive and of minimum width.
- S and R are never asserted together, and a guaranteed low gap follows every pulse.
- The latch Q output is read back through a synchroniser to confirm the latch took the new state, flagging a timeout if it did not.
- Protects the latch from the S=R=1 forbidden input and from runt pulses.

Parameters:
- PULSE_W, 4: cycles s_out/r_out stay high per operation; legal range >=1.
- GAP_W, 2: cycles with both outputs low after each pulse, before readback check; legal range >=1.
- SYNC_STAGES, 2: flop stages on q_fb; legal range >=2.
- TIMEOUT, 16: max CHECK cycles waiting for q_sync to match; legal range >=1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- set_req  in  1  request to set the latch; sampled only when ready=1.
- clr_req  in  1  request to clear the latch; sampled only when ready=1.
- q_fb  in  1  latch Q feedback; asynchronous to clk.
- s_out  out  1  registered drive to latch S.
- r_out  out  1  registered drive to latch R.
- ready  out  1  high in IDLE; a request is accepted on this cycle's edge.
- done  out  1  1-cycle pulse: operation confirmed by readback.
- err_timeout  out  1  1-cycle pulse: readback never matched within TIMEOUT cycles.
- err_conflict  out  1  1-cycle pulse: set_req and clr_req were both high while ready.
- q_sync  out  1  synchronised q_fb (last stage of the chain).

Behaviour:
- Reset (async, immediate):
  - State IDLE; s_out=r_out=0; done=err_timeout=err_conflict=0.
  - Sync chain all 0, so q_sync=0; all counters 0.
  - ready=1 once reset is released.
  - Reset mid-pulse drops s_out/r_out at once, without waiting for a clock; no done/err is produced for the aborted operation.
- States: IDLE, PULSE, GAP, CHECK.
- IDLE (ready=1):
  - Exactly one of set_req/clr_req high at an edge: accept it, latch op (1=set, 0=clr), go to PULSE.
  - Both high: accept neither, pulse err_conflict next cycle, stay IDLE.
  - Neither high: stay IDLE.
- PULSE:
  - Starting the cycle after the accept edge, s_out=op and r_out=~op for exactly PULSE_W cycles.
  - Then both go 0 and the FSM moves to GAP.
- GAP: both outputs 0 for exactly GAP_W cycles, then CHECK.
- CHECK:
  - Each cycle, compare q_sync with op.
  - On match: next edge returns to IDLE and done=1 for one cycle (coincides with ready=1).
  - After TIMEOUT CHECK cycles with no match: return to IDLE with err_timeout=1 for one cycle.
  - Outputs stay 0 throughout CHECK.
- Requests arriving while ready=0 are ignored, not queued.
- s_out and r_out are both flop outputs; s_out & r_out is never 1 in any cycle, including across reset.
- A request that matches the current latch state (e.g. set while q_sync=1) still produces the full pulse and completes with done.
- Nominal latency, accept edge to done edge: PULSE_W + GAP_W + 1 cycles, assuming q_sync is already valid when CHECK starts.
- Counters are sized to hold max(PULSE_W, GAP_W, TIMEOUT); no wrap is permitted.

Test Plan:
- Reset: assert rst mid-PULSE -> s_out=r_out=0 immediately; after release ready=1, q_sync=0, no done or err.
- Set, defaults, bench latch model (q_fb follows s_out, 1-cycle delay), accept at edge 0 -> s_out high after edges 0..3; low gap after edges 4..5; done=1 after edge 7; ready low during edges 0..6; r_out stays 0 throughout.
- Clear after set -> r_out 4 cycles high, s_out stays 0, q_sync falls, done after edge 7; at no cycle is s_out & r_out = 1.
- set_req=clr_req=1 while ready -> err_conflict pulses one cycle, s_out=r_out=0, state stays IDLE.
- q_fb held at 0 during a set -> after 4+2+16 cycles err_timeout pulses once, done never asserts, ready returns to 1.
- set_req pulsed during PULSE and during CHECK -> ignored: exactly one operation and one done.
